// File: rtl/fht_ctrl_pkg.sv
// Shared types and helpers for the FHT frame sequencer.
package fht_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD_RD,
    ST_UNLOAD_OUT
  } state_e;

  localparam int unsigned A_BIT_DEF = 8;
  localparam int unsigned BANK_SIZE = 2 ** A_BIT_DEF;
  localparam int unsigned N         = 4 * BANK_SIZE;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < w; i++) begin
      r = r | (((v >> i) & 32'd1) << (w - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_unload_buf.sv
// Four-word capture buffer drained as a valid/ready stream, word 0 first.
module fht_unload_buf #(
  parameter int unsigned D_BIT = 22
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [D_BIT-1:0] data0_i,
  input  logic [D_BIT-1:0] data1_i,
  input  logic [D_BIT-1:0] data2_i,
  input  logic [D_BIT-1:0] data3_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [D_BIT-1:0] out_data_o,
  output logic             last_acc_o
);

  logic [D_BIT-1:0] word_q [4];
  logic             valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             fire;

  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    fire    = valid_q & out_ready_i;
    if (load_i) begin
      valid_d = 1'b1;
      ptr_d   = '0;
    end else if (fire) begin
      ptr_d = ptr_q + 2'd1;
      if (ptr_q == 2'd3) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ptr_q   <= '0;
      word_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      if (load_i) word_q <= '{data0_i, data1_i, data2_i, data3_i};
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = word_q[ptr_q];
  assign last_acc_o  = fire & (ptr_q == 2'd3);

endmodule

// File: rtl/fht_frame_ctrl.sv
// Frame sequencer: loads ADC samples into the FHT core banks, starts it,
// waits for ready, then streams the result out in bit-reversed row order.
module fht_frame_ctrl
  import fht_ctrl_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 12,
  parameter int unsigned D_BIT     = 22,
  parameter int unsigned A_BIT     = A_BIT_DEF,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned RDY_MASK  = 2
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iADC_VALID,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  output logic                 oADC_READY,
  output logic [3:0]           oWE,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oSTART,
  input  logic                 iRDY,
  output logic [A_BIT-1:0]     oADDR_RD,
  input  logic [D_BIT-1:0]     iDATA_0,
  input  logic [D_BIT-1:0]     iDATA_1,
  input  logic [D_BIT-1:0]     iDATA_2,
  input  logic [D_BIT-1:0]     iDATA_3,
  output logic                 oOUT_VALID,
  output logic [D_BIT-1:0]     oOUT_DATA,
  input  logic                 iOUT_READY,
  output logic                 oBUSY,
  output logic                 oOVF
);

  localparam int unsigned CW  = A_BIT + 2;
  localparam int unsigned LW  = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int unsigned MW  = (RDY_MASK < 1) ? 1 : $clog2(RDY_MASK + 1);
  localparam int unsigned PAD = D_BIT - ADC_WIDTH;
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT);
  localparam logic [MW-1:0] MASK_LAST = MW'(RDY_MASK);

  state_e             state_q, state_d;
  logic [CW-1:0]      load_cnt_q, load_cnt_d;
  logic               load_done_q, load_done_d;
  logic [A_BIT-1:0]   row_q, row_d;
  logic [MW-1:0]      mask_q, mask_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [3:0]         we_q, we_d;
  logic [A_BIT-1:0]   addr_wr_q, addr_wr_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic               ovf_q, ovf_d;
  logic               adc_ready, accept, capture, last_acc;

  // The final write cycle stays in LOAD with ready dropped, so START follows it.
  assign adc_ready = (state_q == ST_LOAD) && !load_done_q;
  assign accept    = adc_ready & iADC_VALID;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    load_done_d = load_done_q;
    row_d       = row_q;
    mask_d      = mask_q;
    lat_d       = lat_q;
    we_d        = '0;
    addr_wr_d   = addr_wr_q;
    data_d      = data_q;
    ovf_d       = ovf_q | (iADC_VALID & ~adc_ready);
    capture     = 1'b0;

    if (accept) begin
      we_d       = 4'b0001 << load_cnt_q[1:0];
      addr_wr_d  = load_cnt_q[CW-1:2];
      data_d     = {iADC_DATA, {PAD{1'b0}}};
      load_cnt_d = load_cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_LOAD: begin
        if (load_done_q) begin
          load_done_d = 1'b0;
          state_d     = ST_START;
        end else if (accept && (load_cnt_q == '1)) begin
          load_done_d = 1'b1;
        end
      end
      ST_START: begin
        mask_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mask_q != MASK_LAST) begin
          mask_d = mask_q + MW'(1);
        end else if (iRDY) begin
          row_d   = '0;
          lat_d   = '0;
          state_d = ST_UNLOAD_RD;
        end
      end
      ST_UNLOAD_RD: begin
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
          lat_d   = '0;
          state_d = ST_UNLOAD_OUT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_UNLOAD_OUT: begin
        if (last_acc) begin
          row_d   = row_q + A_BIT'(1);
          state_d = (row_q == '1) ? ST_LOAD : ST_UNLOAD_RD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      load_done_q <= 1'b0;
      row_q       <= '0;
      mask_q      <= '0;
      lat_q       <= '0;
      we_q        <= '0;
      addr_wr_q   <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      load_done_q <= load_done_d;
      row_q       <= row_d;
      mask_q      <= mask_d;
      lat_q       <= lat_d;
      we_q        <= we_d;
      addr_wr_q   <= addr_wr_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  fht_unload_buf #(
    .D_BIT (D_BIT)
  ) u_unload_buf (
    .clk_i       (iCLK),
    .rst_ni      (iRESET),
    .load_i      (capture),
    .data0_i     (iDATA_0),
    .data1_i     (iDATA_1),
    .data2_i     (iDATA_2),
    .data3_i     (iDATA_3),
    .out_ready_i (iOUT_READY),
    .out_valid_o (oOUT_VALID),
    .out_data_o  (oOUT_DATA),
    .last_acc_o  (last_acc)
  );

  assign oADC_READY = adc_ready;
  assign oWE        = we_q;
  assign oDATA      = data_q;
  assign oADDR_WR   = addr_wr_q;
  assign oSTART     = (state_q == ST_START);
  assign oADDR_RD   = A_BIT'(bitrev(32'(row_q), A_BIT));
  assign oBUSY      = (state_q != ST_LOAD);
  assign oOVF       = ovf_q;

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// Directed bench for fht_frame_ctrl with A_BIT=2 (16-sample frames).
module tb_fht_frame_ctrl;

  logic        iCLK, iRESET, iADC_VALID, oADC_READY, oSTART, iRDY;
  logic [11:0] iADC_DATA;
  logic [3:0]  oWE;
  logic [21:0] oDATA, iDATA_0, iDATA_1, iDATA_2, iDATA_3, oOUT_DATA;
  logic [1:0]  oADDR_WR, oADDR_RD;
  logic        oOUT_VALID, iOUT_READY, oBUSY, oOVF;

  int checks = 0;
  int failures = 0;
  int unsigned frame_base = 0;
  logic [1:0] a1, a2;

  localparam int unsigned EXP_ID[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 4, 5, 6, 7, 12, 13, 14, 15};
  localparam int unsigned RD_EXP[4]  = '{0, 2, 1, 3};

  typedef struct {
    logic        valid;
    logic [11:0] din;
    logic [3:0]  exp_we;
    logic [1:0]  exp_addr;
    logic [21:0] exp_data;
  } vec_t;
  vec_t vec [36];

  fht_frame_ctrl #(
    .ADC_WIDTH (12),
    .D_BIT     (22),
    .A_BIT     (2),
    .RD_LAT    (2),
    .RDY_MASK  (2)
  ) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iADC_VALID (iADC_VALID),
    .iADC_DATA  (iADC_DATA),
    .oADC_READY (oADC_READY),
    .oWE        (oWE),
    .oDATA      (oDATA),
    .oADDR_WR   (oADDR_WR),
    .oSTART     (oSTART),
    .iRDY       (iRDY),
    .oADDR_RD   (oADDR_RD),
    .iDATA_0    (iDATA_0),
    .iDATA_1    (iDATA_1),
    .iDATA_2    (iDATA_2),
    .iDATA_3    (iDATA_3),
    .oOUT_VALID (oOUT_VALID),
    .oOUT_DATA  (oOUT_DATA),
    .iOUT_READY (iOUT_READY),
    .oBUSY      (oBUSY),
    .oOVF       (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Identity core: two-cycle registered read, word = base + row*4 + bank.
  always @(posedge iCLK) begin
    a1 <= oADDR_RD;
    a2 <= a1;
  end
  assign iDATA_0 = 22'(frame_base + 32'(a2) * 4 + 0);
  assign iDATA_1 = 22'(frame_base + 32'(a2) * 4 + 1);
  assign iDATA_2 = 22'(frame_base + 32'(a2) * 4 + 2);
  assign iDATA_3 = 22'(frame_base + 32'(a2) * 4 + 3);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      iADC_VALID = vec[i].valid;
      iADC_DATA  = vec[i].din;
      chk("adc_ready", 32'(oADC_READY), 32'd1);
      step();
      chk("we", 32'(oWE), 32'(vec[i].exp_we));
      if (vec[i].valid) begin
        chk("addr_wr", 32'(oADDR_WR), 32'(vec[i].exp_addr));
        chk("wdata", 32'(oDATA), 32'(vec[i].exp_data));
      end
    end
    iADC_VALID = 1'b0;
  endtask

  // Entered on the final write cycle; returns in the START cycle.
  task automatic after_load();
    chk("wr_cycle_ready", 32'(oADC_READY), 32'd0);
    chk("wr_cycle_start", 32'(oSTART), 32'd0);
    step();
    chk("start", 32'(oSTART), 32'd1);
    chk("start_busy", 32'(oBUSY), 32'd1);
    chk("start_we", 32'(oWE), 32'd0);
  endtask

  task automatic unload(input int unsigned rmod, input int unsigned base);
    int unsigned n = 0;
    int unsigned cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [21:0] pd = '0;
    while (n < 16 && cyc < 300) begin
      iOUT_READY = ((cyc % rmod) == 0);
      if (pv && !pr) begin
        chk("hold_valid", 32'(oOUT_VALID), 32'd1);
        chk("hold_data", 32'(oOUT_DATA), 32'(pd));
      end
      if (oOUT_VALID && iOUT_READY) begin
        chk("out_word", 32'(oOUT_DATA), base + EXP_ID[n]);
        if (n % 4 == 0) chk("addr_rd", 32'(oADDR_RD), RD_EXP[n / 4]);
        if (n == 15) chk("last_acc_ready", 32'(oADC_READY), 32'd0);
        n++;
      end
      pv = oOUT_VALID;
      pd = oOUT_DATA;
      pr = iOUT_READY;
      step();
      cyc++;
    end
    iOUT_READY = 1'b0;
    chk("unload_count", n, 32'd16);
    chk("end_valid", 32'(oOUT_VALID), 32'd0);
    chk("end_busy", 32'(oBUSY), 32'd0);
    chk("end_adc_ready", 32'(oADC_READY), 32'd1);
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!oOUT_VALID && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int unsigned k, lat;
    logic seen;
    for (int i = 0; i < 16; i++) begin
      vec[i].valid    = 1'b1;
      vec[i].din      = 12'(i);
      vec[i].exp_we   = 4'b0001 << (i % 4);
      vec[i].exp_addr = 2'(i / 4);
      vec[i].exp_data = {12'(i), 10'b0};
    end
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 2) begin
        vec[16+i].valid    = 1'b0;
        vec[16+i].din      = 12'h5A5;
        vec[16+i].exp_we   = 4'b0000;
        vec[16+i].exp_addr = 2'd0;
        vec[16+i].exp_data = '0;
      end else begin
        vec[16+i].valid    = 1'b1;
        vec[16+i].din      = 12'hFFF - 12'(k);
        vec[16+i].exp_we   = 4'b0001 << (k % 4);
        vec[16+i].exp_addr = 2'(k / 4);
        vec[16+i].exp_data = {12'hFFF - 12'(k), 10'b0};
        k++;
      end
    end

    iRESET = 1'b0; iADC_VALID = 1'b0; iADC_DATA = '0;
    iRDY = 1'b0; iOUT_READY = 1'b0;
    step(); step();
    chk("rst_we", 32'(oWE), 32'd0);
    chk("rst_start", 32'(oSTART), 32'd0);
    chk("rst_valid", 32'(oOUT_VALID), 32'd0);
    chk("rst_ovf", 32'(oOVF), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_addr_wr", 32'(oADDR_WR), 32'd0);
    chk("rst_addr_rd", 32'(oADDR_RD), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    iRESET = 1'b1;
    step();
    chk("post_rst_ready", 32'(oADC_READY), 32'd1);

    // Frame 1: ramp, stale iRDY through the mask window, then a late pulse.
    apply_vecs(0, 16);
    after_load();
    frame_base = 0;
    iRDY = 1'b1;
    step(); step();
    iRDY = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen |= oOUT_VALID;
    end
    chk("stale_rdy_ignored", 32'(seen), 32'd0);
    chk("wait_busy", 32'(oBUSY), 32'd1);
    iRDY = 1'b1;
    step();
    iRDY = 1'b0;
    chk("rd0_valid", 32'(oOUT_VALID), 32'd0);
    step(); step();
    chk("rd2_valid", 32'(oOUT_VALID), 32'd0);
    step();
    chk("first_valid", 32'(oOUT_VALID), 32'd1);
    unload(1, 0);
    chk("f1_ovf", 32'(oOVF), 32'd0);

    // Frame 2: gapped negative samples, overflow in WAIT, throttled output.
    apply_vecs(16, 36);
    after_load();
    frame_base = 32;
    iRDY = 1'b1;
    step();
    iADC_VALID = 1'b1;
    iADC_DATA  = 12'h123;
    step();
    iADC_VALID = 1'b0;
    chk("ovf_set", 32'(oOVF), 32'd1);
    chk("ovf_we", 32'(oWE), 32'd0);
    wait_valid(lat);
    chk("rdy_to_valid", lat, 32'd5);
    iRDY = 1'b0;
    unload(3, 32);
    chk("ovf_sticky", 32'(oOVF), 32'd1);

    // Frame 3: reset lands mid-UNLOAD_OUT.
    apply_vecs(0, 16);
    chk("ovf_next_frame", 32'(oOVF), 32'd1);
    after_load();
    frame_base = 48;
    iRDY = 1'b1;
    wait_valid(lat);
    chk("f3_valid", 32'(oOUT_VALID), 32'd1);
    iRDY = 1'b0;
    iOUT_READY = 1'b1;
    step(); step();
    iOUT_READY = 1'b0;
    #2 iRESET = 1'b0;
    step();
    chk("abort_valid", 32'(oOUT_VALID), 32'd0);
    chk("abort_ovf", 32'(oOVF), 32'd0);
    chk("abort_busy", 32'(oBUSY), 32'd0);
    chk("abort_we", 32'(oWE), 32'd0);
    iRESET = 1'b1;
    step();
    chk("abort_ready", 32'(oADC_READY), 32'd1);

    // Frame 4: full frame after the abort.
    apply_vecs(0, 16);
    after_load();
    frame_base = 64;
    iRDY = 1'b1;
    wait_valid(lat);
    chk("f4_rdy_to_valid", lat, 32'd7);
    iRDY = 1'b0;
    unload(1, 64);
    chk("f4_ovf", 32'(oOVF), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
